// File: rtl/four_bit_serial_subtractor.sv
// Bit-serial subtractor D = A - B - Bin, LSB first, one borrow flop, START/DONE handshake.
// Optional signed-overflow output OVF is enabled by defining SIGNED_OVF_EN.
module four_bit_serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] D,
  output logic             Bout
`ifdef SIGNED_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    DONE_ST = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic               br_q, br_d;
  logic               bout_q, bout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef SIGNED_OVF_EN
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic               ovf_q, ovf_d;
`endif

  logic               diff_bit;
  logic               borrow_nxt;
  logic [WIDTH-1:0]   res_shift;

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      d_q     <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SIGNED_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      d_q     <= d_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SIGNED_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state and serial full-subtractor cell
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    d_d        = d_q;
    br_d       = br_q;
    bout_d     = bout_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef SIGNED_OVF_EN
    a_msb_d    = a_msb_q;
    b_msb_d    = b_msb_q;
    ovf_d      = ovf_q;
`endif
    diff_bit   = a_q[0] ^ b_q[0] ^ br_q;
    borrow_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    res_shift  = {diff_bit, res_q[WIDTH-1:1]};

    unique case (state_q)
      // DONE_ST accepts a new request so back-to-back operations take WIDTH+1 cycles
      IDLE, DONE_ST: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (START) begin
          state_d = SHIFT;
          a_d     = A;
          b_d     = B;
          br_d    = Bin;
          cnt_d   = '0;
          busy_d  = 1'b1;
`ifdef SIGNED_OVF_EN
          a_msb_d = A[WIDTH-1];
          b_msb_d = B[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = borrow_nxt;
        res_d = res_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE_ST;
          d_d     = res_shift;
          bout_d  = borrow_nxt;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`ifdef SIGNED_OVF_EN
          ovf_d   = (a_msb_q ^ b_msb_q) & (a_msb_q ^ diff_bit);
`endif
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign D    = d_q;
  assign Bout = bout_q;
`ifdef SIGNED_OVF_EN
  assign OVF  = ovf_q;
`endif

endmodule

// File: tb/tb_four_bit_serial_subtractor.sv
// Randomized self-checking bench for four_bit_serial_subtractor against an arithmetic reference.
// Define SIGNED_OVF_EN to also check the OVF output.
module tb_four_bit_serial_subtractor;

  localparam int unsigned WIDTH = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] D;
  logic             Bout;
`ifdef SIGNED_OVF_EN
  logic             OVF;
`endif

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] exp_d;
  logic             exp_bout;
  logic             exp_ovf;

  four_bit_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .START(START),
    .A    (A),
    .B    (B),
    .Bin  (Bin),
    .BUSY (BUSY),
    .DONE (DONE),
    .D    (D),
    .Bout (Bout)
`ifdef SIGNED_OVF_EN
    ,
    .OVF  (OVF)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference: integer arithmetic on the operands, no bit-level modelling
  task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    int r, sa, sb, sr;
    r  = int'(a) - int'(b) - int'(bin);
    sa = a[WIDTH-1] ? int'(a) - (1 << WIDTH) : int'(a);
    sb = b[WIDTH-1] ? int'(b) - (1 << WIDTH) : int'(b);
    sr = sa - sb - int'(bin);
    exp_d    = WIDTH'(r);
    exp_bout = (r < 0);
    exp_ovf  = (sr < -(1 << (WIDTH - 1))) || (sr > (1 << (WIDTH - 1)) - 1);
  endtask

  task automatic check_hold(input string tag);
    check({tag, "_d"}, 32'(D), 32'(exp_d));
    check({tag, "_bout"}, 32'(Bout), 32'(exp_bout));
`ifdef SIGNED_OVF_EN
    check({tag, "_ovf"}, 32'(OVF), 32'(exp_ovf));
`endif
  endtask

  // One operation with optional input noise while busy
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic bin, input bit noisy);
    A = a; B = b; Bin = bin; START = 1'b1;
    step();
    START = 1'b0;
    check("busy_after_start", 32'(BUSY), 32'd1);
    check("done_after_start", 32'(DONE), 32'd0);
    for (int i = 1; i < WIDTH; i++) begin
      if (noisy) begin
        START = 1'($urandom);
        A     = WIDTH'($urandom);
        B     = WIDTH'($urandom);
        Bin   = 1'($urandom);
      end
      step();
      check("busy_mid", 32'(BUSY), 32'd1);
      check("done_mid", 32'(DONE), 32'd0);
      check_hold("hold_mid");
    end
    START = 1'b0;
    step();
    model(a, b, bin);
    check("done_pulse", 32'(DONE), 32'd1);
    check("busy_at_done", 32'(BUSY), 32'd0);
    check_hold("result");
    step();
    check("done_clear", 32'(DONE), 32'd0);
    check("busy_idle", 32'(BUSY), 32'd0);
    check_hold("hold_after");
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; A = '0; B = '0; Bin = 1'b0;
    exp_d = '0; exp_bout = 1'b0; exp_ovf = 1'b0;
    step();
    step();
    RST = 1'b0;
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check_hold("rst");

    run_op(4'd9, 4'd3, 1'b0, 1'b0);
    run_op(4'd3, 4'd9, 1'b0, 1'b0);
    run_op(4'd0, 4'd0, 1'b1, 1'b0);
    run_op(4'd7, 4'd7, 1'b0, 1'b0);
    run_op(4'd8, 4'd1, 1'b0, 1'b0);
    run_op(4'd2, 4'd1, 1'b0, 1'b0);

    // Second START during SHIFT must not disturb the running operation
    A = 4'd5; B = 4'd2; Bin = 1'b0; START = 1'b1;
    step();
    START = 1'b0;
    step();
    START = 1'b1; A = 4'd1; B = 4'd1;
    step();
    START = 1'b0;
    step();
    check("ign_done_early", 32'(DONE), 32'd0);
    step();
    model(4'd5, 4'd2, 1'b0);
    check("ign_done", 32'(DONE), 32'd1);
    check_hold("ign_result");
    for (int i = 0; i < 5; i++) begin
      step();
      check("ign_no_second_done", 32'(DONE), 32'd0);
      check_hold("ign_hold");
    end

    // Reset in the middle of an operation aborts it and clears the result
    A = 4'd12; B = 4'd3; Bin = 1'b1; START = 1'b1;
    step();
    START = 1'b0;
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    exp_d = '0; exp_bout = 1'b0; exp_ovf = 1'b0;
    check("abort_busy", 32'(BUSY), 32'd0);
    check_hold("abort");
    for (int i = 0; i < 6; i++) begin
      step();
      check("abort_no_done", 32'(DONE), 32'd0);
      check("abort_idle_busy", 32'(BUSY), 32'd0);
    end
    run_op(4'd9, 4'd3, 1'b0, 1'b0);

    // Randomized operations with noise and idle gaps
    for (int n = 0; n < 60; n++) begin
      int gap;
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b1);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        A = WIDTH'($urandom); B = WIDTH'($urandom); Bin = 1'($urandom);
        step();
        check("gap_no_done", 32'(DONE), 32'd0);
        check_hold("gap_hold");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
